// File: rtl/uart_pkg.sv
// Shared UART constants and the receive-capture FSM state type.
// Used by uart_rx_fifo, which takes its default word size and FIFO depth from here.
package uart_pkg;

   localparam int WORD_SIZE     = 8;
   localparam int RX_FIFO_DEPTH = 16;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ACK      = 2'd1,
      WAIT_LOW = 2'd2
   } rx_cap_state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO: register-array storage, wrapping pointers and an occupancy count.
// A write is accepted when the FIFO is full only if a pop frees a slot in the same cycle.
module uart_sync_fifo #(
   parameter int WIDTH = uart_pkg::WORD_SIZE,
   parameter int DEPTH = uart_pkg::RX_FIFO_DEPTH,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en_i,
   input  logic [WIDTH-1:0] wr_data_i,
   input  logic             rd_en_i,
   output logic [WIDTH-1:0] rd_data_o,
   output logic [AW:0]      count_o,
   output logic             full_o,
   output logic             empty_o,
   output logic             rd_fire_o
);

   localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [AW:0]      count_q, count_d;
   logic             wr_fire;

   assign full_o    = (count_q == FULL_CNT);
   assign empty_o   = (count_q == '0);
   assign rd_fire_o = rd_en_i & ~empty_o;
   assign wr_fire   = wr_en_i & (~full_o | rd_fire_o);
   assign rd_data_o = mem_q[rd_ptr_q];
   assign count_o   = count_q;

   always_comb begin
      count_d = count_q;
      case ({wr_fire, rd_fire_o})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Storage is left uninitialised on reset; the count alone decides what is valid.
   always_ff @(posedge clk) begin
      if (wr_fire) begin
         mem_q[wr_ptr_q] <= wr_data_i;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (wr_fire)   wr_ptr_q <= wr_ptr_q + 1'b1;
         if (rd_fire_o) rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive buffer: acknowledges each receiver byte once, queues it, and lets the host pop it.
// Optional UART_RX_FIFO_OVF_CNT_EN adds an 8-bit saturating dropped-byte counter (ovf_count).
module uart_rx_fifo #(
   parameter int WORD_SIZE = uart_pkg::WORD_SIZE,
   parameter int DEPTH     = uart_pkg::RX_FIFO_DEPTH
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   enable_data_interrupt,
   input  logic [WORD_SIZE-1:0]   rx_data,
   output logic                   disable_data_interrupt,
   input  logic                   read_nic,
   input  logic                   clr_ovf,
   output logic [WORD_SIZE-1:0]   data_out,
   output logic                   read_nic_i,
   output logic [$clog2(DEPTH):0] count,
   output logic                   overflow
`ifdef UART_RX_FIFO_OVF_CNT_EN
   ,
   output logic [7:0]             ovf_count
`endif
);

   import uart_pkg::*;

   rx_cap_state_t        state_q;
   logic                 ack_q;
   logic                 overflow_q, overflow_d;
   logic [WORD_SIZE-1:0] data_out_q;
   logic [WORD_SIZE-1:0] fifo_rd_data;
   logic                 fifo_full, fifo_empty, fifo_rd_fire;
   logic                 capture, drop;

   // Only IDLE samples the interrupt, so a held request is taken exactly once.
   assign capture = (state_q == IDLE) & enable_data_interrupt;
   assign drop    = capture & fifo_full & ~fifo_rd_fire;

   uart_sync_fifo #(
      .WIDTH (WORD_SIZE),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .wr_en_i   (capture),
      .wr_data_i (rx_data),
      .rd_en_i   (read_nic),
      .rd_data_o (fifo_rd_data),
      .count_o   (count),
      .full_o    (fifo_full),
      .empty_o   (fifo_empty),
      .rd_fire_o (fifo_rd_fire)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         ack_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (enable_data_interrupt) begin
                  state_q <= ACK;
                  ack_q   <= 1'b1;
               end
            end
            ACK: begin
               ack_q   <= 1'b0;
               state_q <= WAIT_LOW;
            end
            WAIT_LOW: begin
               if (!enable_data_interrupt) state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
               ack_q   <= 1'b0;
            end
         endcase
      end
   end

   // A drop in the same cycle as a clear leaves the flag set.
   always_comb begin
      overflow_d = overflow_q;
      if (drop)         overflow_d = 1'b1;
      else if (clr_ovf) overflow_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         data_out_q <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (fifo_rd_fire) data_out_q <= fifo_rd_data;
         overflow_q <= overflow_d;
      end
   end

`ifdef UART_RX_FIFO_OVF_CNT_EN
   logic [7:0] ovf_cnt_q, ovf_cnt_d;

   always_comb begin
      ovf_cnt_d = ovf_cnt_q;
      if (clr_ovf)                         ovf_cnt_d = {7'd0, drop};
      else if (drop && ovf_cnt_q != 8'hFF) ovf_cnt_d = ovf_cnt_q + 8'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) ovf_cnt_q <= '0;
      else     ovf_cnt_q <= ovf_cnt_d;
   end

   assign ovf_count = ovf_cnt_q;
`endif

   assign disable_data_interrupt = ack_q;
   assign data_out               = data_out_q;
   assign overflow               = overflow_q;
   assign read_nic_i             = ~fifo_empty;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: a vector table plus hand sequences for full/overflow/reset.
// Popped data is checked against a scoreboard queue filled as bytes are sent.
module tb_uart_rx_fifo;

   localparam int DEPTH = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       enable_data_interrupt = 1'b0;
   logic [7:0] rx_data = '0;
   logic       disable_data_interrupt;
   logic       read_nic = 1'b0;
   logic       clr_ovf = 1'b0;
   logic [7:0] data_out;
   logic       read_nic_i;
   logic [4:0] count;
   logic       overflow;
`ifdef UART_RX_FIFO_OVF_CNT_EN
   logic [7:0] ovf_count;
`endif

   uart_rx_fifo #(.WORD_SIZE(8), .DEPTH(DEPTH)) dut (
      .clk                    (clk),
      .rst                    (rst),
      .enable_data_interrupt  (enable_data_interrupt),
      .rx_data                (rx_data),
      .disable_data_interrupt (disable_data_interrupt),
      .read_nic               (read_nic),
      .clr_ovf                (clr_ovf),
      .data_out               (data_out),
      .read_nic_i             (read_nic_i),
      .count                  (count),
      .overflow               (overflow)
`ifdef UART_RX_FIFO_OVF_CNT_EN
      ,
      .ovf_count              (ovf_count)
`endif
   );

   always #10 clk = ~clk;

   int         n_vec = 0;
   int         n_err = 0;
   int         ack_cnt = 0;
   logic [7:0] sb[$];
   logic [7:0] last_out = 8'h00;
   int         m_ovfcnt = 0;

   typedef struct {
      bit         is_pop;
      logic [7:0] data;
      int         hold;
      logic [7:0] exp_data;
      int         exp_count;
      bit         exp_ovf;
   } vec_t;

   vec_t vecs[7];

   always @(negedge clk) begin
      if (disable_data_interrupt === 1'b1) ack_cnt++;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] d, input int hold);
      int a0;
      a0 = ack_cnt;
      $display("write 0x%02h held %0d cycles", d, hold);
      enable_data_interrupt = 1'b1;
      rx_data = d;
      repeat (hold) step();
      enable_data_interrupt = 1'b0;
      repeat (2) step();
      if (sb.size() < DEPTH) sb.push_back(d);
      else if (m_ovfcnt < 255) m_ovfcnt++;
      chk("ack_pulses", ack_cnt - a0, 1);
   endtask

   task automatic pop();
      logic [7:0] e;
      read_nic = 1'b1;
      step();
      read_nic = 1'b0;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         last_out = e;
         $display("pop expect 0x%02h got 0x%02h", e, data_out);
         chk("pop_data", int'(data_out), int'(e));
      end else begin
         $display("pop on empty, data_out 0x%02h", data_out);
         chk("pop_empty_hold", int'(data_out), int'(last_out));
      end
   endtask

   initial begin
      vecs[0] = '{1'b0, 8'h55, 5,  8'h00, 1, 1'b0};
      vecs[1] = '{1'b0, 8'hAA, 5,  8'h00, 2, 1'b0};
      vecs[2] = '{1'b1, 8'h00, 0,  8'h55, 1, 1'b0};
      vecs[3] = '{1'b1, 8'h00, 0,  8'hAA, 0, 1'b0};
      vecs[4] = '{1'b0, 8'h3C, 20, 8'hAA, 1, 1'b0};
      vecs[5] = '{1'b1, 8'h00, 0,  8'h3C, 0, 1'b0};
      vecs[6] = '{1'b1, 8'h00, 0,  8'h3C, 0, 1'b0};

      repeat (3) step();
      rst = 1'b0;
      step();
      $display("reset released");
      chk("rst_data_out", int'(data_out), 0);
      chk("rst_count", int'(count), 0);
      chk("rst_read_nic_i", int'(read_nic_i), 0);
      chk("rst_overflow", int'(overflow), 0);
      chk("rst_ack", int'(disable_data_interrupt), 0);

      pop();
      chk("empty_pop_count", int'(count), 0);

      foreach (vecs[i]) begin
         if (vecs[i].is_pop) pop();
         else send_byte(vecs[i].data, vecs[i].hold);
         chk("vec_count", int'(count), vecs[i].exp_count);
         chk("vec_read_nic_i", int'(read_nic_i), int'(vecs[i].exp_count != 0));
         chk("vec_overflow", int'(overflow), int'(vecs[i].exp_ovf));
         chk("vec_data_out", int'(data_out), int'(vecs[i].exp_data));
      end

      // Fill past capacity: the 17th byte is dropped.
      for (int i = 0; i < 17; i++) send_byte(8'(i), 1);
      chk("full_count", int'(count), DEPTH);
      chk("full_read_nic_i", int'(read_nic_i), 1);
      chk("full_overflow", int'(overflow), 1);
`ifdef UART_RX_FIFO_OVF_CNT_EN
      chk("full_ovf_count", int'(ovf_count), m_ovfcnt);
`endif

      clr_ovf = 1'b1;
      step();
      clr_ovf = 1'b0;
      m_ovfcnt = 0;
      $display("clear overflow");
      chk("clr_overflow", int'(overflow), 0);
`ifdef UART_RX_FIFO_OVF_CNT_EN
      chk("clr_ovf_count", int'(ovf_count), 0);
`endif

      // Full FIFO, capture and pop on the same edge: write accepted, no overflow.
      begin
         logic [7:0] e;
         int a0;
         a0 = ack_cnt;
         $display("write 0x77 with simultaneous pop while full");
         enable_data_interrupt = 1'b1;
         rx_data = 8'h77;
         read_nic = 1'b1;
         step();
         read_nic = 1'b0;
         e = sb.pop_front();
         last_out = e;
         sb.push_back(8'h77);
         chk("simul_pop_data", int'(data_out), int'(e));
         chk("simul_count", int'(count), DEPTH);
         chk("simul_overflow", int'(overflow), 0);
         enable_data_interrupt = 1'b0;
         repeat (2) step();
         chk("simul_ack_pulses", ack_cnt - a0, 1);
      end

      // Drop and clear in the same cycle: set wins.
      $display("write 0xEE while full with clr_ovf");
      enable_data_interrupt = 1'b1;
      rx_data = 8'hEE;
      clr_ovf = 1'b1;
      step();
      clr_ovf = 1'b0;
      chk("dropclr_overflow", int'(overflow), 1);
      chk("dropclr_count", int'(count), DEPTH);
`ifdef UART_RX_FIFO_OVF_CNT_EN
      chk("dropclr_ovf_count", int'(ovf_count), 1);
`endif
      enable_data_interrupt = 1'b0;
      repeat (2) step();

      repeat (DEPTH) pop();
      chk("drain_count", int'(count), 0);
      chk("drain_read_nic_i", int'(read_nic_i), 0);

      // Reset mid-ack with five words queued.
      for (int i = 0; i < 5; i++) send_byte(8'hA0 + 8'(i), 1);
      $display("write 0xB5 then reset during ack");
      enable_data_interrupt = 1'b1;
      rx_data = 8'hB5;
      step();
      chk("midack_ack", int'(disable_data_interrupt), 1);
      chk("midack_count", int'(count), 6);
      rst = 1'b1;
      step();
      chk("mrst_count", int'(count), 0);
      chk("mrst_read_nic_i", int'(read_nic_i), 0);
      chk("mrst_ack", int'(disable_data_interrupt), 0);
      chk("mrst_data_out", int'(data_out), 0);
      chk("mrst_overflow", int'(overflow), 0);
      rst = 1'b0;
      step();
      chk("post_rst_capture_count", int'(count), 1);
      enable_data_interrupt = 1'b0;
      repeat (2) step();
      sb.delete();
      sb.push_back(8'hB5);
      last_out = 8'h00;
      pop();
      chk("post_rst_count", int'(count), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
